spi_sensor_poll_ctrl: RTL and testbench

//   Sequencer for the SPI sensor reader. Requests one sensor byte from the SPI master every

---
 rtl/spi_sensor_poll_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_sensor_poll_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_poll_ctrl.sv
// Periodic SPI sensor poller: requests one byte from the SPI master every PERIOD_CYCLES
// and stores it into a circular sample memory, flagging frame completion and timeouts.
module spi_sensor_poll_ctrl #(
  parameter int PERIOD_CYCLES = 1000,
  parameter int ADDR_W        = 4,
  parameter int FRAME_LEN     = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              spi_valid,
  input  logic              spi_ready,
  input  logic [7:0]        spi_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int PCNT_W = $clog2(PERIOD_CYCLES);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int FCNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_DRAIN = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t            state;
  logic [PCNT_W-1:0] pcnt;
  logic [TCNT_W-1:0] tcnt;
  logic [FCNT_W-1:0] fcnt;

  assign dbg_state = state;

  // Handshake: spi_valid rises on REQ entry and stays high until the first cycle spi_ready
  // is sampled high (spi_data is captured on that same edge) or the timeout expires; the
  // master must then release spi_ready, which DRAIN waits for before any new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      spi_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      pcnt        <= '0;
      tcnt        <= '0;
      fcnt        <= '0;
    end else begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      if (state != S_IDLE && pcnt != PCNT_LAST) pcnt <= pcnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state       <= S_REQ;
            spi_valid   <= 1'b1;
            busy        <= 1'b1;
            pcnt        <= '0;
            tcnt        <= '0;
            fcnt        <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_REQ: begin
          // Ready is checked before the timeout so a last-cycle response still wins.
          if (spi_ready) begin
            mem_wdata <= spi_data;
            mem_we    <= 1'b1;
            spi_valid <= 1'b0;
            state     <= S_WRITE;
          end else if (tcnt == TCNT_LAST) begin
            timeout_err <= 1'b1;
            spi_valid   <= 1'b0;
            state       <= S_DRAIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WRITE: begin
          mem_addr <= mem_addr + 1'b1;
          if (fcnt == FCNT_LAST) begin
            fcnt       <= '0;
            frame_done <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
          state <= S_DRAIN;
        end
        S_DRAIN, S_WAIT: begin
          // An overrun period (pcnt saturated) restarts straight out of DRAIN.
          if (state == S_WAIT || !spi_ready) begin
            if (pcnt != PCNT_LAST) begin
              state <= S_WAIT;
            end else if (enable) begin
              state     <= S_REQ;
              spi_valid <= 1'b1;
              pcnt      <= '0;
              tcnt      <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          spi_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sensor_poll_ctrl.sv
// Bench for spi_sensor_poll_ctrl: SPI responder model, scoreboard of expected RAM writes,
// and one task per scenario; a second small instance exercises address wrap-around.
module tb_spi_sensor_poll_ctrl;

  localparam int AW        = 4;
  localparam int FRAME_LEN = 8;
  localparam int W         = 1 + AW + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst = 1'b1, enable = 1'b0;
  logic          spi_valid, spi_ready = 1'b0;
  logic [7:0]    spi_data = 8'h00;
  logic          mem_we, frame_done, timeout_err, busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [2:0]    dbg_state;

  logic       rst2 = 1'b1, enable2 = 1'b0;
  logic       valid2, ready2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       we2, fd2, err2, busy2;
  logic [1:0] addr2;
  logic [7:0] wdata2;
  logic [2:0] st2;

  spi_sensor_poll_ctrl #(.PERIOD_CYCLES(1000), .ADDR_W(AW), .FRAME_LEN(FRAME_LEN), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .spi_valid(spi_valid), .spi_ready(spi_ready),
    .spi_data(spi_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .frame_done(frame_done), .timeout_err(timeout_err), .busy(busy), .dbg_state(dbg_state)
  );

  spi_sensor_poll_ctrl #(.PERIOD_CYCLES(16), .ADDR_W(2), .FRAME_LEN(4), .TIMEOUT(8)) u_dut2 (
    .clk(clk), .rst(rst2), .enable(enable2), .spi_valid(valid2), .spi_ready(ready2),
    .spi_data(data2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .frame_done(fd2), .timeout_err(err2), .busy(busy2), .dbg_state(st2)
  );

  int checks = 0, failures = 0;
  logic [W-1:0] exp_q[$];
  logic [9:0]   exp2_q[$];

  int         resp_delay = 40;
  bit         resp_rand  = 1'b0;
  bit         resp_en    = 1'b1;
  logic [7:0] base_data  = 8'h50;
  logic [7:0] resp_step  = 8'h00;

  int m_wr = 0, m_fcnt = 0, r_cnt = 0, r_delay = 0, ready_cyc = 0;
  int wr_seen = 0, fd_cnt = 0, rise_cnt = 0, rise_cyc = 0, last_gap = 0;
  bit fd_pend = 1'b0, fd_exp = 1'b0, valid_prev = 1'b0;
  int n2 = 0, r2_cnt = 0, w2_seen = 0, fd2_cnt = 0;
  logic [W-1:0] e;
  logic [9:0]   e2;

  // Monitor, scoreboard and SPI responder for both instances, all on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      spi_ready = 1'b0; r_cnt = 0; m_wr = 0; m_fcnt = 0; fd_pend = 1'b0; valid_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (fd_pend) begin
        checks++;
        if (frame_done !== fd_exp) begin
          failures++; $display("FAIL frame_done got=%0b exp=%0b", frame_done, fd_exp);
        end
        fd_pend = 1'b0;
      end else if (frame_done) begin
        checks++; failures++; $display("FAIL frame_done_unexpected got=1 exp=0");
      end
      if (frame_done) fd_cnt++;
      if (mem_we) begin
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL write_unexpected addr=%0h data=%0h exp=none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== e[AW+7:0]) begin
            failures++;
            $display("FAIL write_addr_data got=%0h/%0h exp=%0h/%0h", mem_addr, mem_wdata, e[AW+7:8], e[7:0]);
          end
          checks++;
          if (cyc - ready_cyc != 1) begin
            failures++; $display("FAIL write_latency got=%0d exp=1", cyc - ready_cyc);
          end
          fd_pend = 1'b1; fd_exp = e[W-1];
        end
      end
      if (spi_valid && !valid_prev) begin
        rise_cnt++; last_gap = cyc - rise_cyc; rise_cyc = cyc;
      end
      valid_prev = spi_valid;
      if (spi_ready) begin
        if (!spi_valid) spi_ready = 1'b0;
      end else if (spi_valid && resp_en) begin
        if (r_cnt == 0) r_delay = resp_rand ? int'($urandom_range(1, 60)) : resp_delay;
        r_cnt++;
        if (r_cnt >= r_delay) begin
          spi_data  = base_data + resp_step * 8'(m_wr);
          spi_ready = 1'b1;
          ready_cyc = cyc;
          exp_q.push_back({(m_fcnt == FRAME_LEN - 1), AW'(m_wr % 16), spi_data});
          m_fcnt = (m_fcnt == FRAME_LEN - 1) ? 0 : m_fcnt + 1;
          m_wr++;
          r_cnt = 0;
        end
      end else begin
        r_cnt = 0;
      end
    end

    if (rst2) begin
      ready2 = 1'b0; r2_cnt = 0; exp2_q.delete();
    end else begin
      if (fd2) fd2_cnt++;
      if (we2) begin
        w2_seen++;
        checks++;
        if (exp2_q.size() == 0) begin
          failures++; $display("FAIL wrap_write_unexpected addr=%0d exp=none", addr2);
        end else begin
          e2 = exp2_q.pop_front();
          if ({addr2, wdata2} !== e2) begin
            failures++; $display("FAIL wrap_addr_data got=%0d/%0h exp=%0d/%0h", addr2, wdata2, e2[9:8], e2[7:0]);
          end
        end
      end
      if (ready2) begin
        if (!valid2) ready2 = 1'b0;
      end else if (valid2) begin
        r2_cnt++;
        if (r2_cnt >= 2) begin
          data2  = 8'hA0 + 8'(n2);
          ready2 = 1'b1;
          exp2_q.push_back({2'(n2 % 4), data2});
          n2++;
          r2_cnt = 0;
        end
      end else begin
        r2_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    enable = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_valid, mem_we, frame_done, timeout_err, busy} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%05b exp=00000", {spi_valid, mem_we, frame_done, timeout_err, busy});
    end
    checks++;
    if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", mem_addr); end
    checks++;
    if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", mem_wdata); end
    checks++;
    if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_first_sample();
    int w0, r0;
    do_reset();
    resp_rand = 1'b0; resp_delay = 40; base_data = 8'h50; resp_step = 8'h00; resp_en = 1'b1;
    @(negedge clk);
    checks++;
    if (spi_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_before got=%0b exp=0", spi_valid); end
    w0 = wr_seen; r0 = rise_cnt;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (spi_valid !== 1'b1) begin failures++; $display("FAIL t1_valid_after_enable got=%0b exp=1", spi_valid); end
    for (int i = 0; i < 100 && wr_seen == w0; i++) @(negedge clk);
    checks++;
    if (wr_seen != w0 + 1) begin failures++; $display("FAIL t1_write_count got=%0d exp=1", wr_seen - w0); end
    for (int i = 0; i < 1100 && rise_cnt < r0 + 2; i++) @(negedge clk);
    checks++;
    if (rise_cnt < r0 + 2 || last_gap != 1000) begin
      failures++; $display("FAIL t1_period got=%0d exp=1000", last_gap);
    end
    enable = 1'b0;
  endtask

  task automatic test_frame();
    int w0, f0;
    do_reset();
    resp_rand = 1'b1; base_data = 8'h01; resp_step = 8'h01;
    w0 = wr_seen; f0 = fd_cnt;
    enable = 1'b1;
    for (int i = 0; i < 9500 && wr_seen < w0 + 8; i++) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_seen != w0 + 8) begin failures++; $display("FAIL t2_write_count got=%0d exp=8", wr_seen - w0); end
    checks++;
    if (fd_cnt != f0 + 1) begin failures++; $display("FAIL t2_frame_done_count got=%0d exp=1", fd_cnt - f0); end
    resp_rand = 1'b0;
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    enable2 = 1'b1;
    for (int i = 0; i < 500 && w2_seen < 5; i++) @(negedge clk);
    enable2 = 1'b0;
    for (int i = 0; i < 200 && busy2; i++) @(negedge clk);
    checks++;
    if (w2_seen != 5) begin failures++; $display("FAIL t3_write_count got=%0d exp=5", w2_seen); end
    checks++;
    if (addr2 !== 2'd1) begin failures++; $display("FAIL t3_final_addr got=%0d exp=1", addr2); end
    checks++;
    if ({busy2, err2, st2} !== 5'b0) begin failures++; $display("FAIL t3_idle got=%05b exp=00000", {busy2, err2, st2}); end
    checks++;
    if (fd2_cnt != 1) begin failures++; $display("FAIL t3_frame_done_count got=%0d exp=1", fd2_cnt); end
  endtask

  task automatic test_timeout();
    int hi, w0;
    do_reset();
    resp_en = 1'b0; base_data = 8'h33; resp_step = 8'h00;
    enable = 1'b1;
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (spi_valid) hi++;
      else if (hi > 0) break;
    end
    checks++;
    if (hi != 255) begin failures++; $display("FAIL t4_valid_cycles got=%0d exp=255", hi); end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL t4_err_set got=%0b exp=1", timeout_err); end
    enable = 1'b0;
    for (int i = 0; i < 1200 && busy; i++) @(negedge clk);
    checks++;
    if ({busy, timeout_err} !== 2'b01) begin failures++; $display("FAIL t4_idle_sticky got=%02b exp=01", {busy, timeout_err}); end
    resp_en = 1'b1; resp_delay = 10;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({timeout_err, spi_valid} !== 2'b01) begin
      failures++; $display("FAIL t4_err_clear got=%02b exp=01", {timeout_err, spi_valid});
    end
    w0 = wr_seen;
    for (int i = 0; i < 100 && wr_seen == w0; i++) @(negedge clk);
    checks++;
    if (wr_seen != w0 + 1) begin failures++; $display("FAIL t4_resume got=%0d exp=1", wr_seen - w0); end
    resp_delay = 255;
    w0 = wr_seen;
    for (int i = 0; i < 1400 && wr_seen == w0; i++) @(negedge clk);
    checks++;
    if (wr_seen != w0 + 1 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL t4_ready_wins got=%0d/%0b exp=1/0", wr_seen - w0, timeout_err);
    end
    resp_delay = 256;
    w0 = wr_seen;
    for (int i = 0; i < 1400 && !timeout_err; i++) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || wr_seen != w0) begin
      failures++; $display("FAIL t4_ready_late got=%0b/%0d exp=1/0", timeout_err, wr_seen - w0);
    end
    enable = 1'b0;
    resp_delay = 40;
  endtask

  task automatic test_disable_mid();
    int w0, v;
    do_reset();
    resp_delay = 40;
    w0 = wr_seen;
    enable = 1'b1;
    for (int i = 0; i < 10 && !spi_valid; i++) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 1500 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_seen != w0 + 1) begin
      failures++; $display("FAIL t5_complete got=busy%0b/w%0d exp=busy0/w1", busy, wr_seen - w0);
    end
    v = 0;
    repeat (50) begin @(negedge clk); if (spi_valid) v++; end
    checks++;
    if (v != 0) begin failures++; $display("FAIL t5_no_request got=%0d exp=0", v); end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    resp_delay = 40;
    enable = 1'b1;
    for (int i = 0; i < 10 && !spi_valid; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({spi_valid, mem_we, mem_addr, mem_wdata, frame_done, timeout_err, busy, dbg_state} !== 20'h0) begin
      failures++; $display("FAIL t6_reset_in_req got=%05h exp=0", {spi_valid, mem_we, mem_addr, mem_wdata, frame_done, timeout_err, busy, dbg_state});
    end
    rst = 1'b0;
    for (int i = 0; i < 200 && !mem_we; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({spi_valid, mem_we, mem_addr, mem_wdata, frame_done, timeout_err, busy, dbg_state} !== 20'h0) begin
      failures++; $display("FAIL t6_reset_in_write got=%05h exp=0", {spi_valid, mem_we, mem_addr, mem_wdata, frame_done, timeout_err, busy, dbg_state});
    end
    enable = 1'b0;
    rst = 1'b0;
    w = 0;
    repeat (20) begin @(negedge clk); if (mem_we) w++; end
    checks++;
    if (w != 0) begin failures++; $display("FAIL t6_no_write_after_reset got=%0d exp=0", w); end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_frame();
    test_wrap();
    test_timeout();
    test_disable_mid();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      failures++; $display("FAIL pending_expected got=%0d/%0d exp=0/0", exp_q.size(), exp2_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
